// File: rtl/cp0_regs.sv
// cp0_regs: CP0 Status/Cause/EPC/BadVAddr/Count/Compare registers
// with exception commit, eret and timer/interrupt request generation.
module cp0_regs #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic        wb_bd,
  input  logic [4:0]  wb_excode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic        eret_flush,
  input  logic [5:0]  ext_int_in,
  input  logic [7:0]  cp0_addr,
  input  logic        mtc0_we,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic        int_req
);

  localparam logic [7:0] A_BADV = 8'h40;
  localparam logic [7:0] A_CNT  = 8'h48;
  localparam logic [7:0] A_CMP  = 8'h58;
  localparam logic [7:0] A_STAT = 8'h60;
  localparam logic [7:0] A_CAUS = 8'h68;
  localparam logic [7:0] A_EPC  = 8'h70;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [5:0]  iph_q, iph_d;
  logic [1:0]  ips_q, ips_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bad_q, bad_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        tick_q, tick_d;
  logic        irq_q, irq_d;
  logic        mtc;
  logic        inc;

  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    ti_d   = ti_q;
    ips_d  = ips_q;
    exc_d  = exc_q;
    epc_d  = epc_q;
    bad_d  = bad_q;
    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    mtc    = mtc0_we & ~wb_ex;
    inc    = (COUNT_DIV == 1) ? 1'b1 : tick_q;
    tick_d = (COUNT_DIV == 1) ? 1'b0 : ~tick_q;

    if (mtc && cp0_addr == A_CNT) begin
      cnt_d  = cp0_wdata;
      tick_d = 1'b0;
      inc    = 1'b0;
    end else if (inc) begin
      cnt_d = cnt_q + 32'd1;
    end

    // A Compare write wins over a same-edge match
    if (mtc && cp0_addr == A_CMP) begin
      cmp_d = cp0_wdata;
      ti_d  = 1'b0;
    end else if (inc && cnt_d == cmp_q) begin
      ti_d = 1'b1;
    end

    if (mtc && cp0_addr == A_STAT) begin
      im_d  = cp0_wdata[15:8];
      exl_d = cp0_wdata[1];
      ie_d  = cp0_wdata[0];
    end
    if (mtc && cp0_addr == A_CAUS) ips_d = cp0_wdata[9:8];
    if (mtc && cp0_addr == A_EPC)  epc_d = cp0_wdata;

    iph_d = {ext_int_in[5] | ti_d, ext_int_in[4:0]};

    if (wb_ex) begin
      exl_d = 1'b1;
      exc_d = wb_excode;
      if (!exl_q) begin
        epc_d = wb_bd ? wb_pc - 32'd4 : wb_pc;
        bd_d  = wb_bd;
      end
      if (wb_excode == 5'h04 || wb_excode == 5'h05) bad_d = wb_badvaddr;
    end else if (eret_flush) begin
      exl_d = 1'b0;
    end

    irq_d = ie_q & ~exl_q & (|({iph_q, ips_q} & im_q));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      ti_q   <= 1'b0;
      iph_q  <= '0;
      ips_q  <= '0;
      exc_q  <= '0;
      epc_q  <= '0;
      bad_q  <= '0;
      cnt_q  <= '0;
      cmp_q  <= '0;
      tick_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      ti_q   <= ti_d;
      iph_q  <= iph_d;
      ips_q  <= ips_d;
      exc_q  <= exc_d;
      epc_q  <= epc_d;
      bad_q  <= bad_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      tick_q <= tick_d;
      irq_q  <= irq_d;
    end
  end

  assign cp0_status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cp0_cause  = {bd_q, ti_q, 14'b0, iph_q, ips_q, 1'b0, exc_q, 2'b0};
  assign cp0_epc    = epc_q;
  assign int_req    = irq_q;

  always_comb begin
    case (cp0_addr)
      A_BADV:  cp0_rdata = bad_q;
      A_CNT:   cp0_rdata = cnt_q;
      A_CMP:   cp0_rdata = cmp_q;
      A_STAT:  cp0_rdata = cp0_status;
      A_CAUS:  cp0_rdata = cp0_cause;
      A_EPC:   cp0_rdata = epc_q;
      default: cp0_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed plus random checks of cp0_regs against
// a field-level reference model of the CP0 rules.
`timescale 1ns/1ps
module tb_cp0_regs;

  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_ex = 1'b0;
  logic        wb_bd = 1'b0;
  logic [4:0]  wb_excode = '0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_badvaddr = '0;
  logic        eret_flush = 1'b0;
  logic [5:0]  ext_int_in = '0;
  logic [7:0]  cp0_addr = '0;
  logic        mtc0_we = 1'b0;
  logic [31:0] cp0_wdata = '0;
  logic [31:0] cp0_rdata, cp0_epc, cp0_status, cp0_cause;
  logic        int_req;

  cp0_regs #(.COUNT_DIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .wb_ex(wb_ex), .wb_bd(wb_bd),
    .wb_excode(wb_excode), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
    .eret_flush(eret_flush), .ext_int_in(ext_int_in),
    .cp0_addr(cp0_addr), .mtc0_we(mtc0_we), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .cp0_epc(cp0_epc), .cp0_status(cp0_status),
    .cp0_cause(cp0_cause), .int_req(int_req)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd, m_ti, m_irq;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_bad, m_cnt, m_cmp;
  int          m_ph;

  logic [7:0] addrs [8] = '{8'h40, 8'h48, 8'h58, 8'h60,
                            8'h68, 8'h70, 8'h00, 8'h41};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip) << 8)
         | (32'(m_exc) << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h40:   return m_bad;
      8'h48:   return m_cnt;
      8'h58:   return m_cmp;
      8'h60:   return m_status();
      8'h68:   return m_cause();
      8'h70:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
    m_irq = 0; m_exc = '0; m_epc = '0; m_bad = '0; m_cnt = '0;
    m_cmp = '0; m_ph = 0;
  endtask

  task automatic model_step();
    logic mt, inc, old_exl;
    logic [31:0] wd;
    mt = mtc0_we && !wb_ex;
    wd = cp0_wdata;
    old_exl = m_exl;
    m_irq = m_ie && !m_exl && ((m_ip & m_im) != 8'h00);
    inc = 0;
    if (mt && cp0_addr == 8'h48) begin
      m_cnt = wd;
      m_ph = 0;
    end else begin
      m_ph = (m_ph + 1) % DIV;
      if (m_ph == 0) begin
        m_cnt = m_cnt + 1;
        inc = 1;
      end
    end
    if (mt && cp0_addr == 8'h58) begin
      m_cmp = wd;
      m_ti = 0;
    end else if (inc && m_cnt == m_cmp) begin
      m_ti = 1;
    end
    if (mt && cp0_addr == 8'h60) begin
      m_im = wd[15:8];
      m_exl = wd[1];
      m_ie = wd[0];
    end
    if (mt && cp0_addr == 8'h68) m_ip[1:0] = wd[9:8];
    if (mt && cp0_addr == 8'h70) m_epc = wd;
    m_ip[7:2] = {ext_int_in[5] | m_ti, ext_int_in[4:0]};
    if (wb_ex) begin
      m_exl = 1;
      m_exc = wb_excode;
      if (!old_exl) begin
        m_epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
        m_bd = wb_bd;
      end
      if (wb_excode == 5'h04 || wb_excode == 5'h05) m_bad = wb_badvaddr;
    end else if (eret_flush) begin
      m_exl = 0;
    end
  endtask

  task automatic check_all();
    chk("epc", cp0_epc, m_epc);
    chk("status", cp0_status, m_status());
    chk("cause", cp0_cause, m_cause());
    chk("int_req", 32'(int_req), 32'(m_irq));
    chk("rdata", cp0_rdata, m_read(cp0_addr));
  endtask

  task automatic idle();
    wb_ex = 0; wb_bd = 0; wb_excode = '0; wb_pc = '0; wb_badvaddr = '0;
    eret_flush = 0; mtc0_we = 0; cp0_wdata = '0; cp0_addr = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    idle();
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    mtc0_we = 1; cp0_addr = a; cp0_wdata = d;
    cyc();
  endtask

  task automatic except(input logic [4:0] c, input logic [31:0] pc,
                        input logic bd, input logic [31:0] bv);
    wb_ex = 1; wb_excode = c; wb_pc = pc; wb_bd = bd; wb_badvaddr = bv;
    cyc();
  endtask

  task automatic rd(input logic [7:0] a, input string tag,
                    input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  initial begin
    model_reset();
    idle();
    repeat (3) @(negedge clk);
    resetn = 1;
    rd(8'h40, "rst_badv", 32'h0);
    rd(8'h48, "rst_count", 32'h0);
    rd(8'h58, "rst_compare", 32'h0);
    rd(8'h60, "rst_status", 32'h0040_0000);
    rd(8'h68, "rst_cause", 32'h0);
    rd(8'h70, "rst_epc", 32'h0);
    chk("rst_int_req", 32'(int_req), 32'h0);
    idle();

    except(5'h08, 32'hBFC0_0100, 1'b1, 32'h0);
    chk("ex_epc", cp0_epc, 32'hBFC0_00FC);
    chk("ex_cause", cp0_cause, 32'h8000_0020);
    chk("ex_exl", 32'(cp0_status[1]), 32'h1);
    except(5'h08, 32'h0000_1000, 1'b0, 32'h0);
    chk("ex2_epc_hold", cp0_epc, 32'hBFC0_00FC);
    eret_flush = 1;
    cyc();
    chk("eret_exl", 32'(cp0_status[1]), 32'h0);

    mtc0(8'h60, 32'h0040_8001);
    mtc0(8'h58, 32'd5);
    mtc0(8'h48, 32'd0);
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (cp0_cause[30]) break;
    end
    chk("timer_ti", 32'(cp0_cause[30]), 32'h1);
    chk("timer_ip7", 32'(cp0_cause[15]), 32'h1);
    rd(8'h48, "timer_count", 32'd5);
    idle();
    cyc();
    chk("timer_irq", 32'(int_req), 32'h1);
    mtc0(8'h58, 32'hFFFF_0000);
    chk("cmp_clr_ti", 32'(cp0_cause[30]), 32'h0);

    except(5'h04, 32'h0000_2000, 1'b0, 32'h8000_0003);
    rd(8'h40, "adel_badv", 32'h8000_0003);
    idle();
    except(5'h0C, 32'h0000_2004, 1'b0, 32'h1234_5678);
    rd(8'h40, "ov_badv_hold", 32'h8000_0003);
    idle();
    eret_flush = 1;
    cyc();

    mtc0_we = 1; cp0_addr = 8'h60; cp0_wdata = 32'hFFFF_FFFF;
    wb_ex = 1; wb_excode = 5'h0C; wb_pc = 32'h0000_3000;
    cyc();
    chk("mtc0_vs_ex", cp0_status, 32'h0040_8003);
    eret_flush = 1;
    cyc();
    mtc0(8'h68, 32'hFFFF_FFFF);
    chk("cause_sw", 32'(cp0_cause[9:8]), 32'h3);
    mtc0(8'h68, 32'h0);

    mtc0(8'h60, 32'h0040_1001);
    ext_int_in = 6'b000100;
    cyc();
    chk("ext_ip4", 32'(cp0_cause[12]), 32'h1);
    cyc();
    chk("ext_irq", 32'(int_req), 32'h1);

    #3 resetn = 0;
    #1;
    model_reset();
    check_all();
    chk("async_status", cp0_status, 32'h0040_0000);
    @(negedge clk);
    resetn = 1;
    check_all();

    for (int n = 0; n < 400; n++) begin
      wb_ex = ($urandom % 10) == 0;
      eret_flush = ($urandom % 10) == 0;
      case ($urandom % 4)
        0: wb_excode = 5'h04;
        1: wb_excode = 5'h05;
        2: wb_excode = 5'h08;
        default: wb_excode = 5'($urandom);
      endcase
      wb_pc = $urandom & 32'hFFFF_FFFC;
      wb_bd = $urandom % 2;
      wb_badvaddr = $urandom;
      if (($urandom % 6) == 0) ext_int_in = 6'($urandom);
      cp0_addr = addrs[$urandom % 8];
      mtc0_we = ($urandom % 4) == 0;
      cp0_wdata = $urandom;
      if (cp0_addr == 8'h58) cp0_wdata = m_cnt + $urandom_range(1, 8);
      if (cp0_addr == 8'h48 && ($urandom % 2))
        cp0_wdata = m_cmp - $urandom_range(1, 4);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_regs.md
Name: cp0_regs

Overview:
- Coprocessor-0 register file and exception/timer responder. It services the write-back stage's CP0 requests: mtc0 writes, mfc0 reads, exception commit and eret.
- Holds Status, Cause, EPC, BadVAddr, Count and Compare.
- Returns the EPC, Status and Cause views and an interrupt request, which the front end uses for flush and redirect.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (legal values 1 or 2).

Ports:
- clk  input  1  core clock; all state on rising edge
- resetn  input  1  asynchronous active-low reset
- wb_ex  input  1  valid exception committing in WB this cycle
- wb_bd  input  1  excepting instruction is in a branch delay slot
- wb_excode  input  5  exception code
- wb_pc  input  32  PC of excepting instruction
- wb_badvaddr  input  32  faulting address for AdEL/AdES
- eret_flush  input  1  valid eret committing in WB
- ext_int_in  input  6  external interrupt lines, level-sensitive
- cp0_addr  input  8  {rd[4:0], sel[2:0]} for mfc0/mtc0
- mtc0_we  input  1  mtc0 write strobe (WB already gates valid and !ex)
- cp0_wdata  input  32  mtc0 data
- cp0_rdata  output  32  mfc0 read data, combinational from cp0_addr
- cp0_epc  output  32  current EPC
- cp0_status  output  32  current Status
- cp0_cause  output  32  current Cause
- int_req  output  1  registered interrupt pending, to be taken at WB

Behaviour:
- Address map ({rd,sel}):
  - BadVAddr 8/0 = 0x40
  - Count 9/0 = 0x48
  - Compare 11/0 = 0x58
  - Status 12/0 = 0x60
  - Cause 13/0 = 0x68
  - EPC 14/0 = 0x70
  - Any other address reads 0; writes to it are ignored.
- Reset (resetn low, asynchronous):
  - Status = 0x0040_0000 (BEV = 1, IM = 0, EXL = 0, IE = 0).
  - Cause, EPC, BadVAddr, Count, Compare and the divide tick all = 0.
  - int_req = 0.
  - Outputs follow the registers.
- Status fields:
  - BEV[22] is read-only 1.
  - IM[15:8] is mtc0-writable.
  - EXL[1] is writable by mtc0, set by wb_ex, cleared by eret_flush.
  - IE[0] is mtc0-writable.
  - All other bits read 0.
- Cause fields:
  - BD[31] and ExcCode[6:2] are written only by exceptions.
  - TI[30]: set when Count == Compare after a Count update; cleared only by an mtc0 to Compare.
  - IP[7:2] sampled every clock: IP[7] = ext_int_in[5] | TI, IP[6:2] = ext_int_in[4:0].
  - IP[1:0] is software-writable by mtc0.
  - All other bits are 0.
- Exception commit (wb_ex = 1):
  - EXL <= 1; Cause.ExcCode <= wb_excode.
  - If the old EXL = 0: EPC <= wb_bd ? wb_pc - 4 : wb_pc (32-bit wrap) and Cause.BD <= wb_bd.
  - If the old EXL = 1: EPC and BD are unchanged.
  - If wb_excode is 0x04 or 0x05: BadVAddr <= wb_badvaddr.
- eret_flush: EXL <= 0 at the next edge. If wb_ex and eret_flush are both high, wb_ex wins.
- mtc0 priority: any mtc0 in the same cycle as wb_ex is ignored. Otherwise mtc0 to EPC, Status, Cause[9:8], Compare or Count takes effect at the next edge.
- Count/Compare timing:
  - Count increments by 1 on each divide tick, wrapping 0xFFFF_FFFF -> 0.
  - An mtc0 to Count loads Count and clears the tick phase.
  - An mtc0 to Compare loads Compare and clears TI in the same edge; a match on that same edge does not set TI.
- mfc0: cp0_rdata reflects the register value before the current edge. There is no write-to-read bypass; same-cycle mtc0/mfc0 to the same register returns the old value.
- int_req (registered, one cycle after the condition):
  - Condition: Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
  - Deasserts one cycle after EXL is set.

Test Plan:
1. Reset then read all six registers -> Status = 0x0040_0000, all others 0, int_req = 0.
2. wb_ex = 1, excode 0x08, pc = 0xBFC0_0100, bd = 1 -> next cycle:
   - EPC = 0xBFC0_00FC, Cause = 0x8000_0020, Status.EXL = 1.
   - A second wb_ex with pc 0x1000 leaves EPC unchanged.
   - eret_flush clears EXL.
3. mtc0 Compare = 5, Count = 0, COUNT_DIV = 2 -> Count reaches 5 about 10 clocks later, then TI = 1 and Cause[15] = 1. With Status = 0x0040_8001, int_req = 1 the following cycle. mtc0 Compare clears TI.
4. excode 0x04 with badvaddr 0x8000_0003 -> BadVAddr = 0x8000_0003. excode 0x0C -> BadVAddr unchanged.
5. mtc0 Status and wb_ex in the same cycle -> Status keeps the pre-write IM/IE; only EXL = 1. A write of 0xFFFF_FFFF to Cause -> Cause[9:8] = 2'b11, other bits unchanged.
6. ext_int_in = 6'b000100 with Status = 0x0040_1001 -> Cause[12] = 1 after one clock, int_req = 1 one clock later. Asserting resetn low mid-run clears all state immediately, without waiting for clk.
